// File: rtl/hw_barrier_event_dispatch_pkg.sv
// Shared event-unit definitions for the barrier event dispatcher.
package hw_barrier_event_dispatch_pkg;

  localparam int unsigned NB_BARRIERS_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } disp_state_e;

endpackage

// File: rtl/hw_barrier_rr_pick.sv
// Combinational round-robin first-one finder: lowest set request at or
// above the pointer, wrapping modulo N.
module hw_barrier_rr_pick
  import hw_barrier_event_dispatch_pkg::*;
#(
  parameter int unsigned N   = NB_BARRIERS_DEF,
  parameter int unsigned IDW = 3
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [IDW-1:0] gnt_idx_o,
  output logic           gnt_valid_o
);

  always_comb begin
    int unsigned idx;
    idx         = 0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      // Explicit wrap keeps the scan correct for non-power-of-two N.
      idx = 32'(ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid_o && req_i[IDW'(idx)]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/hw_barrier_event_dispatch.sv
// Per-core dispatch of barrier events: pending register, round-robin pick,
// single in-flight valid/ready slot and sticky overflow.
module hw_barrier_event_dispatch
  import hw_barrier_event_dispatch_pkg::*;
#(
  parameter  int unsigned NB_CORES    = 4,
  parameter  int unsigned NB_BARRIERS = NB_BARRIERS_DEF,
  localparam int unsigned ID_W        = (NB_BARRIERS > 1) ? $clog2(NB_BARRIERS) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [NB_BARRIERS-1:0][NB_CORES-1:0]    barrier_events_i,
  input  logic [NB_CORES-1:0]                     clear_i,
  output logic [NB_CORES-1:0]                     event_valid_o,
  output logic [NB_CORES-1:0][ID_W-1:0]           event_id_o,
  input  logic [NB_CORES-1:0]                     event_ready_i,
  output logic [NB_CORES-1:0][NB_BARRIERS-1:0]    pending_o,
  output logic [NB_CORES-1:0]                     overflow_o
);

  for (genvar c = 0; c < NB_CORES; c++) begin : g_core
    logic [NB_BARRIERS-1:0] arr;
    logic [NB_BARRIERS-1:0] cand;
    logic [NB_BARRIERS-1:0] pend_d, pend_q;
    disp_state_e            state_d, state_q;
    logic [ID_W-1:0]        id_d, id_q;
    logic [ID_W-1:0]        rr_d, rr_q;
    logic [ID_W-1:0]        gnt_idx;
    logic                   gnt_valid;
    logic                   ovf_d, ovf_q;

    always_comb begin
      arr = '0;
      for (int unsigned b = 0; b < NB_BARRIERS; b++) begin
        arr[b] = barrier_events_i[b][c];
      end
    end

    assign cand = pend_q | arr;

    hw_barrier_rr_pick #(
      .N   (NB_BARRIERS),
      .IDW (ID_W)
    ) i_rr_pick (
      .req_i       (cand),
      .ptr_i       (rr_q),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
    );

    always_comb begin
      state_d = state_q;
      id_d    = id_q;
      rr_d    = rr_q;
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      if (clear_i[c]) begin
        state_d = IDLE;
        id_d    = '0;
        rr_d    = '0;
        pend_d  = '0;
        ovf_d   = 1'b0;
      end else begin
        // Merge arrivals first; the selected bit is then removed so the
        // in-flight event never also sits in pending.
        pend_d = pend_q | arr;
        ovf_d  = ovf_q | (|(pend_q & arr));
        if (state_q == IDLE || event_ready_i[c]) begin
          if (gnt_valid) begin
            state_d         = HOLD;
            id_d            = gnt_idx;
            pend_d[gnt_idx] = 1'b0;
            rr_d            = (32'(gnt_idx) == NB_BARRIERS - 1) ? '0 : gnt_idx + 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        id_q    <= '0;
        rr_q    <= '0;
        pend_q  <= '0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        id_q    <= id_d;
        rr_q    <= rr_d;
        pend_q  <= pend_d;
        ovf_q   <= ovf_d;
      end
    end

    assign event_valid_o[c] = (state_q == HOLD);
    assign event_id_o[c]    = id_q;
    assign pending_o[c]     = pend_q;
    assign overflow_o[c]    = ovf_q;
  end

endmodule

// File: tb/tb_hw_barrier_event_dispatch.sv
module tb_hw_barrier_event_dispatch;

  localparam int unsigned NC  = 4;
  localparam int unsigned NB  = 8;
  localparam int unsigned IDW = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NB-1:0][NC-1:0]   ev;
  logic [NC-1:0]           clr;
  logic [NC-1:0]           valid;
  logic [NC-1:0][IDW-1:0]  id;
  logic [NC-1:0]           ready;
  logic [NC-1:0][NB-1:0]   pend;
  logic [NC-1:0]           ovf;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned exp_q [NC][$];

  always #5 clk = ~clk;

  hw_barrier_event_dispatch #(
    .NB_CORES    (NC),
    .NB_BARRIERS (NB)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .barrier_events_i (ev),
    .clear_i          (clr),
    .event_valid_o    (valid),
    .event_id_o       (id),
    .event_ready_i    (ready),
    .pending_o        (pend),
    .overflow_o       (ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake that will complete at the next edge is compared
  // against the oldest expected id for that core.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < NC; c++) begin
        if (valid[c] && ready[c]) begin
          n_cmp++;
          if (exp_q[c].size() == 0) begin
            n_fail++;
            $display("FAIL hs_core%0d: got unexpected id %0d expected none", c, id[c]);
          end else begin
            int unsigned e;
            e = exp_q[c].pop_front();
            if (32'(id[c]) != e) begin
              n_fail++;
              $display("FAIL hs_core%0d: got id %0d expected %0d", c, id[c], e);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ev    = '0;
    clr   = '0;
    ready = '1;
    tick();
    tick();
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_id", 64'(id), 64'h0);
    chk("rst_pend", 64'(pend), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    rst_n = 1'b1;
    tick();

    // Single event on core 1, barrier 3
    ev[3][1] = 1'b1;
    exp_q[1].push_back(3);
    tick();
    ev = '0;
    chk("single_valid", 64'(valid), 64'h2);
    chk("single_id", 64'(id[1]), 64'd3);
    tick();
    chk("single_drop", 64'(valid), 64'h0);

    // Round-robin on core 0: {1,5,6} then wrap check from pointer 7
    ev[1][0] = 1'b1; ev[5][0] = 1'b1; ev[6][0] = 1'b1;
    exp_q[0].push_back(1); exp_q[0].push_back(5); exp_q[0].push_back(6);
    tick();
    ev = '0;
    chk("rr_id1", 64'(id[0]), 64'd1);
    chk("rr_pend1", 64'(pend[0]), 64'h60);
    tick();
    chk("rr_id5", 64'(id[0]), 64'd5);
    chk("rr_valid5", 64'(valid[0]), 64'h1);
    chk("rr_pend5", 64'(pend[0]), 64'h40);
    tick();
    chk("rr_id6", 64'(id[0]), 64'd6);
    chk("rr_pend6", 64'(pend[0]), 64'h00);
    tick();
    chk("rr_idle", 64'(valid[0]), 64'h0);
    ev[0][0] = 1'b1; ev[7][0] = 1'b1;
    exp_q[0].push_back(7); exp_q[0].push_back(0);
    tick();
    ev = '0;
    chk("wrap_id7", 64'(id[0]), 64'd7);
    chk("wrap_pend", 64'(pend[0]), 64'h01);
    tick();
    chk("wrap_id0", 64'(id[0]), 64'd0);
    tick();
    chk("wrap_idle", 64'(valid[0]), 64'h0);

    // Backpressure on core 2
    ready = 4'b1011;
    ev[2][2] = 1'b1;
    exp_q[2].push_back(2); exp_q[2].push_back(4);
    tick();
    ev = '0;
    chk("bp_id2", 64'(id[2]), 64'd2);
    ev[4][2] = 1'b1;
    tick();
    ev = '0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_id", 64'(id[2]), 64'd2);
      chk("bp_hold_pend", 64'(pend[2]), 64'h10);
      if (i < 4) tick();
    end
    ready = '1;
    tick();
    chk("bp_id4", 64'(id[2]), 64'd4);
    chk("bp_valid4", 64'(valid[2]), 64'h1);
    tick();
    chk("bp_idle", 64'(valid[2]), 64'h0);

    // Overflow on core 0 stalled on id 7, then clear
    ready = 4'b1110;
    ev[7][0] = 1'b1;
    tick();
    ev = '0;
    chk("ovf_id7", 64'(id[0]), 64'd7);
    ev[0][0] = 1'b1;
    tick();
    ev = '0;
    chk("ovf_pend_a", 64'(pend[0]), 64'h01);
    chk("ovf_flag_a", 64'(ovf[0]), 64'h0);
    ev[0][0] = 1'b1;
    tick();
    ev = '0;
    chk("ovf_pend_b", 64'(pend[0]), 64'h01);
    chk("ovf_flag_b", 64'(ovf), 64'h1);
    clr = 4'b0001;
    tick();
    clr = '0;
    chk("clr_valid", 64'(valid[0]), 64'h0);
    chk("clr_pend", 64'(pend[0]), 64'h0);
    chk("clr_ovf", 64'(ovf), 64'h0);
    ready = '1;

    // Clear and arrival together on core 2; core 3 unaffected
    ev[4][2] = 1'b1;
    ev[5][3] = 1'b1;
    clr = 4'b0100;
    exp_q[3].push_back(5);
    tick();
    clr = '0;
    ev = '0;
    chk("sim_pend2", 64'(pend[2]), 64'h0);
    chk("sim_valid", 64'(valid), 64'h8);
    chk("sim_id3", 64'(id[3]), 64'd5);
    tick();
    chk("sim_idle", 64'(valid), 64'h0);

    // Reset while core 1 holds an event
    ready = 4'b1101;
    ev[6][1] = 1'b1;
    tick();
    ev = '0;
    chk("rh_valid", 64'(valid), 64'h2);
    chk("rh_id6", 64'(id[1]), 64'd6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rh_rst_valid", 64'(valid), 64'h0);
    chk("rh_rst_id", 64'(id), 64'h0);
    chk("rh_rst_pend", 64'(pend), 64'h0);
    chk("rh_rst_ovf", 64'(ovf), 64'h0);
    ready = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rh_no_valid", 64'(valid), 64'h0);
    end

    for (int c = 0; c < NC; c++) begin
      chk("queue_empty", 64'(exp_q[c].size()), 64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
